seg7_scan_driver: RTL and testbench

SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

---
 rtl/seg7_pkg.sv | 29 ++
 rtl/seg7_decode.sv | 25 ++
 rtl/seg7_scan_driver.sv | 156 +++++++++++++++
 tb/tb_seg7_scan_driver.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared 7-segment codes (active-low {g,f,e,d,c,b,a}), converter state type and sizing helper
// for the seg7_scan_driver slice.
package seg7_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        COMMIT
    } state_t;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    // Decimal digits needed for the largest bin_w-bit value: floor(bin_w*log10(2)) + 1.
    function automatic int bcd_digits(input int bin_w);
        return (bin_w * 30103) / 100000 + 1;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD nibble to active-low 7-segment decoder; codes 10-15 render blank.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        case (nibble)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Binary to multiplexed 7-segment display: sequential double-dabble converter plus digit scanner.
// Define SEG7_LEADING_ZERO_BLANK_EN to blank zero digits above the most significant nonzero one.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int BIN_W       = 14,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [BIN_W-1:0]      bin,
    input  logic                  load,
    output logic                  busy,
    output logic [6:0]            seg,
    output logic [NUM_DIGITS-1:0] an
);

    localparam int BCD_N  = (bcd_digits(BIN_W) > NUM_DIGITS) ? bcd_digits(BIN_W) : NUM_DIGITS;
    localparam int BCD_W  = 4 * BCD_N;
    localparam int DISP_W = 4 * NUM_DIGITS;
    localparam int CNT_W  = $clog2(REFRESH_DIV);
    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int BITS_W = $clog2(BIN_W + 1);

    state_t              state, state_next;
    logic [BITS_W-1:0]   bit_cnt;
    logic [BIN_W-1:0]    bin_sr;
    logic [BCD_W-1:0]    bcd, bcd_next;
    logic [DISP_W-1:0]   disp;
    logic                ovf, ovf_next;
    logic [CNT_W-1:0]    ref_cnt;
    logic [IDX_W-1:0]    idx;
    logic [3:0]          nib;
    logic [6:0]          dec_seg, seg_next;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: default assignment first so no path through always_comb leaves a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (load) state_next = SHIFT;
            SHIFT:   if (bit_cnt == BITS_W'(BIN_W - 1)) state_next = COMMIT;
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    // One double-dabble step: correct every nibble >= 5, then shift in the next binary MSB.
    always_comb begin
        bcd_next = bcd;
        for (int i = 0; i < BCD_N; i++) begin
            if (bcd_next[4*i +: 4] >= 4'd5) bcd_next[4*i +: 4] = bcd_next[4*i +: 4] + 4'd3;
        end
        bcd_next = {bcd_next[BCD_W-2:0], bin_sr[BIN_W-1]};
    end

    always_comb begin
        ovf_next = 1'b0;
        for (int i = NUM_DIGITS; i < BCD_N; i++) begin
            ovf_next = ovf_next | (bcd[4*i +: 4] != 4'd0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt <= '0;
            bin_sr  <= '0;
            bcd     <= '0;
            disp    <= '0;
            ovf     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (load) begin
                    bin_sr  <= bin;
                    bcd     <= '0;
                    bit_cnt <= '0;
                end
                SHIFT: begin
                    bcd     <= bcd_next;
                    bin_sr  <= bin_sr << 1;
                    bit_cnt <= bit_cnt + BITS_W'(1);
                end
                COMMIT: begin
                    disp <= bcd[DISP_W-1:0];
                    ovf  <= ovf_next;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ref_cnt <= '0;
            idx     <= '0;
        end else if (ref_cnt == CNT_W'(REFRESH_DIV - 1)) begin
            ref_cnt <= '0;
            idx     <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
        end else begin
            ref_cnt <= ref_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        nib = disp[idx*4 +: 4];
    end

    seg7_decode u_decode (
        .nibble (nib),
        .seg    (dec_seg)
    );

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] lead_zero;
    logic                  seen;

    // Walk from the top digit down; digit 0 is never blanked.
    always_comb begin
        seen      = 1'b0;
        lead_zero = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            seen         = seen | (disp[4*i +: 4] != 4'd0);
            lead_zero[i] = !seen && (i != 0);
        end
    end
`endif

    always_comb begin
        seg_next = dec_seg;
        if (ovf) seg_next = SEG_DASH;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        else if (lead_zero[idx]) seg_next = SEG_BLANK;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            an  <= '1;
            seg <= SEG_BLANK;
        end else begin
            an  <= ~(NUM_DIGITS'(1) << idx);
            seg <= seg_next;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver (4 digits, 14-bit input, 4-cycle digit slots).
module tb_seg7_scan_driver;

    localparam logic [6:0] BLANK = 7'b1111111;
    localparam logic [6:0] DASH  = 7'b0111111;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load = 1'b0;
    logic [13:0] bin = '0;
    logic        busy;
    logic [6:0]  seg;
    logic [3:0]  an;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        string           name;
        logic [3:0][6:0] segs;
    } disp_exp_t;

    disp_exp_t sb_q[$];

    seg7_scan_driver #(
        .NUM_DIGITS  (4),
        .BIN_W       (14),
        .REFRESH_DIV (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bin   (bin),
        .load  (load),
        .busy  (busy),
        .seg   (seg),
        .an    (an)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // 0-9 digit codes, 10 = dash, anything else = blank.
    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0:  return 7'b1000000;
            1:  return 7'b1111001;
            2:  return 7'b0100100;
            3:  return 7'b0110000;
            4:  return 7'b0011001;
            5:  return 7'b0010010;
            6:  return 7'b0000010;
            7:  return 7'b1111000;
            8:  return 7'b0000000;
            9:  return 7'b0010000;
            10: return DASH;
            default: return BLANK;
        endcase
    endfunction

    function automatic disp_exp_t mk(input string name, input int d3, input int d2, input int d1, input int d0);
        disp_exp_t e;
        e.name    = name;
        e.segs[0] = seg_of(d0);
        e.segs[1] = seg_of(d1);
        e.segs[2] = seg_of(d2);
        e.segs[3] = seg_of(d3);
        return e;
    endfunction

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    localparam int LZ = 11;
`else
    localparam int LZ = 0;
`endif

    // Monitor: each new an value is one digit presentation; consume a whole display (4 digits) per entry.
    disp_exp_t  cur;
    bit         active = 1'b0;
    int         remaining = 0;
    int         pres = 0;
    int         cyc = 0;
    int         last_cyc = 0;
    bit         have_prev = 1'b0;
    logic [3:0] prev_an = 4'hF;
    logic [3:0] exp_an;
    int         dig;

    always @(negedge clk) begin
        cyc++;
        if (an == 4'hF) begin
            pres      = 0;
            have_prev = 1'b0;
            prev_an   = 4'hF;
        end else if (an != prev_an) begin
            dig = pres % 4;
            if (!active && sb_q.size() > 0) begin
                cur       = sb_q.pop_front();
                remaining = 4;
                active    = 1'b1;
            end
            if (active) begin
                exp_an = ~(4'b0001 << dig);
                check($sformatf("%s_an_d%0d", cur.name, dig), an, exp_an);
                check($sformatf("%s_seg_d%0d", cur.name, dig), seg, cur.segs[dig]);
                if (have_prev) check($sformatf("%s_slot_len_d%0d", cur.name, dig), cyc - last_cyc, 4);
                remaining--;
                if (remaining == 0) active = 1'b0;
            end
            prev_an   = an;
            last_cyc  = cyc;
            have_prev = 1'b1;
            pres++;
        end
    end

    task automatic drain(input string name);
        int n = 0;
        while ((sb_q.size() != 0 || active) && n < 400) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("%s_drained", name), sb_q.size() + int'(active), 0);
    endtask

    // Load v; optionally hold load with a second value for one more edge while busy.
    task automatic run_load(input string name, input int v, input bit second, input int v2);
        int n = 0;
        @(negedge clk);
        bin  = 14'(v);
        load = 1'b1;
        @(negedge clk);
        load = second;
        if (second) bin = 14'(v2);
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
            load = 1'b0;
        end
        check($sformatf("%s_busy_len", name), n, 15);
        @(negedge clk);
    endtask

    initial begin
        sb_q.push_back(mk("scan_reset", LZ, LZ, LZ, 0));
        @(negedge clk);
        check("reset_an", an, 4'hF);
        check("reset_seg", seg, BLANK);
        check("reset_busy", busy, 1'b0);
        reset = 1'b0;
        drain("scan_reset");

        run_load("bcd_1234", 1234, 1'b0, 0);
        sb_q.push_back(mk("bcd_1234", 1, 2, 3, 4));
        drain("bcd_1234");

        run_load("bcd_9999", 9999, 1'b1, 5);
        sb_q.push_back(mk("bcd_9999", 9, 9, 9, 9));
        drain("bcd_9999");

        run_load("ovf_12000", 12000, 1'b0, 0);
        sb_q.push_back(mk("ovf_12000", 10, 10, 10, 10));
        drain("ovf_12000");

        run_load("bcd_7", 7, 1'b0, 0);
        sb_q.push_back(mk("bcd_7", LZ, LZ, LZ, 7));
        drain("bcd_7");

        @(negedge clk);
        bin  = 14'd42;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (5) @(negedge clk);
        check("abort_busy_mid", busy, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        check("abort_busy", busy, 1'b0);
        check("abort_an", an, 4'hF);
        check("abort_seg", seg, BLANK);
        reset = 1'b0;
        sb_q.push_back(mk("abort_zero", LZ, LZ, LZ, 0));
        @(negedge clk);
        check("abort_first_an", an, 4'b1110);
        check("abort_first_seg", seg, 7'b1000000);
        drain("abort_zero");
        check("abort_busy_idle", busy, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit, %0d/%0d passed", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
